// File: rtl/xbar_wt_loader.sv
// Crossbar weight-memory loader: stages a streamed weight image
// and commits it to the weight memory with a single prog_wt pulse.
module xbar_wt_loader #(
  parameter int XBAR_SIZE = 4,
  parameter int WT_BITS   = 8,
  parameter int LANES     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ld_start,
  input  logic                       ld_abort,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*WT_BITS-1:0]   in_data,
  output logic                       ld_busy,
  output logic                       ld_done,
  output logic                       prog_wt,
  output logic [XBAR_SIZE*XBAR_SIZE-1:0][WT_BITS-1:0] wr_weight
);

  localparam int NW    = XBAR_SIZE * XBAR_SIZE;
  localparam int BEATS = NW / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  generate
    if ((NW % LANES) != 0) begin : g_bad_lanes
      $error("image size must be a multiple of LANES");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    COMMIT
  } state_t;

  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic          take;
  logic          done_q;
  logic [NW-1:0][WT_BITS-1:0] staging;

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    prog_wt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (ld_start) state_nx = FILL;
      end
      FILL: begin
        in_ready = 1'b1;
        if (ld_abort)
          state_nx = IDLE;
        else if (in_valid && cnt == LAST)
          state_nx = COMMIT;
      end
      COMMIT: begin
        prog_wt  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // An abort wins over a beat presented in the same cycle.
  assign take      = in_valid & in_ready & ~ld_abort;
  assign ld_busy   = (state != IDLE);
  assign ld_done   = done_q;
  assign wr_weight = staging;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= (state == COMMIT);
      if (state != FILL || ld_abort)
        cnt <= '0;
      else if (take)
        cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      staging <= '0;
    end else if (take) begin
      for (int j = 0; j < NW; j++) begin
        if (cnt == CW'(j / LANES))
          staging[j] <= in_data[(j % LANES)*WT_BITS +: WT_BITS];
      end
    end
  end

endmodule

// File: tb/tb_xbar_wt_loader.sv
// Bench for xbar_wt_loader: image loads against an array model
// of the staged image and a paired weight memory.
module tb_xbar_wt_loader;

  localparam int XS    = 4;
  localparam int WB    = 8;
  localparam int LN    = 4;
  localparam int NW    = XS * XS;
  localparam int BEATS = NW / LN;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ld_start = 1'b0;
  logic ld_abort = 1'b0;
  logic in_valid = 1'b0;
  logic [LN*WB-1:0] in_data = '0;
  logic in_ready, ld_busy, ld_done, prog_wt;
  logic [NW-1:0][WB-1:0] wr_weight;

  xbar_wt_loader #(
    .XBAR_SIZE(XS),
    .WT_BITS  (WB),
    .LANES    (LN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ld_start (ld_start),
    .ld_abort (ld_abort),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .ld_busy  (ld_busy),
    .ld_done  (ld_done),
    .prog_wt  (prog_wt),
    .wr_weight(wr_weight)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int prog_cnt = 0;
  int done_cnt = 0;
  logic [WB-1:0] mem [NW];
  logic [WB-1:0] img [NW];
  logic [WB-1:0] prev [NW];

  // Paired weight memory: captures the image on each program strobe.
  always @(posedge clk) begin
    if (prog_wt) begin
      prog_cnt <= prog_cnt + 1;
      for (int j = 0; j < NW; j++) mem[j] <= wr_weight[j];
    end
    if (ld_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mem_vec();
    logic [127:0] v = '0;
    for (int j = 0; j < NW; j++) v[j*WB +: WB] = mem[j];
    return v;
  endfunction

  function automatic logic [127:0] img_vec();
    logic [127:0] v = '0;
    for (int j = 0; j < NW; j++) v[j*WB +: WB] = img[j];
    return v;
  endfunction

  task automatic drive_beat(input int b);
    in_valid = 1'b1;
    for (int l = 0; l < LN; l++)
      in_data[l*WB +: WB] = img[b*LN + l];
  endtask

  task automatic load(input int gap, input bit rnd_gap,
                      input bit start_mid, input bit noise_commit);
    int p0;
    int d0;
    int g;
    p0 = prog_cnt;
    d0 = done_cnt;
    @(negedge clk);
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    check("rdy_t1", in_ready, 1);
    check("busy_fill", ld_busy, 1);
    for (int b = 0; b < BEATS; b++) begin
      g = (b == 0) ? 0 : (rnd_gap ? $urandom_range(0, gap) : gap);
      for (int k = 0; k < g; k++) begin
        in_valid = 1'b0;
        @(negedge clk);
        check("stall_nopg", prog_wt, 0);
      end
      drive_beat(b);
      if (start_mid && b == 2) ld_start = 1'b1;
      @(negedge clk);
      ld_start = 1'b0;
    end
    in_valid = 1'b0;
    check("prog_n1", prog_wt, 1);
    check("rdy_commit", in_ready, 0);
    check("busy_commit", ld_busy, 1);
    if (noise_commit) begin
      ld_start = 1'b1;
      ld_abort = 1'b1;
    end
    @(negedge clk);
    ld_start = 1'b0;
    ld_abort = 1'b0;
    check("prog_n2", prog_wt, 0);
    check("done_n2", ld_done, 1);
    check("busy_n2", ld_busy, 0);
    @(negedge clk);
    check("done_n3", ld_done, 0);
    check("rdy_after", in_ready, 0);
    check("prog_pulses", 128'(prog_cnt - p0), 1);
    check("done_pulses", 128'(done_cnt - d0), 1);
    check("image", mem_vec(), img_vec());
  endtask

  initial begin
    int p0;
    int d0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Idle after reset
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("rst_prog", prog_wt, 0);
      check("rst_rdy", in_ready, 0);
      check("rst_busy", ld_busy, 0);
      check("rst_done", ld_done, 0);
    end
    check("rst_img", wr_weight, 0);

    // Back-to-back ramp image
    for (int j = 0; j < NW; j++) img[j] = WB'(j);
    load(0, 0, 0, 0);
    check("row2", {mem[8], mem[9], mem[10], mem[11]}, 32'h08090a0b);

    // Same image with 3-cycle gaps
    load(3, 0, 0, 0);

    // Abort with the third beat
    for (int j = 0; j < NW; j++) prev[j] = img[j];
    for (int j = 0; j < NW; j++) img[j] = WB'(8'h50 + j);
    p0 = prog_cnt;
    d0 = done_cnt;
    @(negedge clk);
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      drive_beat(b);
      if (b == 2) ld_abort = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    ld_abort = 1'b0;
    check("abort_rdy", in_ready, 0);
    check("abort_busy", ld_busy, 0);
    check("abort_w0", wr_weight[0], img[0]);
    check("abort_w5", wr_weight[5], img[5]);
    check("abort_w8", wr_weight[8], prev[8]);
    check("abort_w11", wr_weight[11], prev[11]);
    repeat (4) @(negedge clk);
    check("abort_prog", 128'(prog_cnt - p0), 0);
    check("abort_done", 128'(done_cnt - d0), 0);
    for (int j = 0; j < NW; j++) img[j] = WB'(8'hA0 + j);
    load(0, 0, 0, 0);

    // Noise on ld_start/ld_abort during FILL and COMMIT
    for (int j = 0; j < NW; j++) img[j] = WB'($urandom);
    load(1, 1, 1, 1);

    // Reset after beat 3 of 4
    p0 = prog_cnt;
    for (int j = 0; j < NW; j++) img[j] = WB'($urandom);
    @(negedge clk);
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      drive_beat(b);
      @(negedge clk);
    end
    in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_img", wr_weight, 0);
    check("mid_rst_rdy", in_ready, 0);
    check("mid_rst_busy", ld_busy, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_prog", 128'(prog_cnt - p0), 0);
    for (int j = 0; j < NW; j++) img[j] = WB'($urandom);
    load(0, 0, 0, 0);

    // Random images, gaps and control noise
    for (int it = 0; it < 8; it++) begin
      for (int j = 0; j < NW; j++) img[j] = WB'($urandom);
      load(4, 1, 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
